// File: rtl/cpu_fabric_op_bridge.sv
// CPU-side operand/result bridge for the east CPU I/O tile column.
// Serialises two operands as nibble beats onto OPA/OPB and collects a nibble-beat result.
module cpu_fabric_op_bridge #(
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                  UserCLK,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [DATA_WIDTH-1:0] cmd_rs1,
  input  logic [DATA_WIDTH-1:0] cmd_rs2,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [3:0]            rsp_status,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [3:0]            opa_o,
  output logic [3:0]            opb_o,
  input  logic [3:0]            res0_i,
  input  logic [3:0]            res1_i,
  input  logic [3:0]            res2_i,
  output logic [2:0]            dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // valid is never withdrawn before that edge and the payload is stable while valid is high.

  localparam int NB = DATA_WIDTH / 4;
  localparam int CW = $clog2(NB + 1);
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] NB_CNT   = CW'(NB);
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);
  localparam logic [TW-1:0] TMAX     = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_SEND    = 3'd2,
    S_COLLECT = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  state_t                  state_q, state_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [CW-1:0]           count_q, count_nx;
  logic [TW-1:0]           timer_q;
  logic [DATA_WIDTH-1:0]   rs1_q, rs2_q;
  logic                    capture, full_now, expire, accept;
  logic [3:0]              opa_d, opb_d;
  logic                    unused_res1;

  assign unused_res1 = ^res1_i[3:2];
  assign cmd_ready   = (state_q == S_IDLE);
  assign dbg_state   = state_q;
  assign accept      = (state_q == S_IDLE) && cmd_valid;

  // A beat is taken only while a frame is open and the result is not yet full.
  always_comb begin
    capture = 1'b0;
    if (state_q == S_START || state_q == S_SEND || state_q == S_COLLECT)
      capture = res1_i[0] && (count_q < NB_CNT);
  end

  assign count_nx = count_q + CW'(capture);
  assign full_now = (count_nx == NB_CNT);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    expire  = 1'b0;
    case (state_q)
      S_IDLE:    if (cmd_valid) state_d = S_START;
      S_START: begin
        state_d = S_SEND;
        idx_d   = '0;
      end
      S_SEND: begin
        if (idx_q == LAST_IDX) state_d = full_now ? S_DONE : S_COLLECT;
        else                   idx_d   = idx_q + 1'b1;
      end
      S_COLLECT: begin
        // Completion takes priority over an expiry in the same cycle.
        if (full_now) begin
          state_d = S_DONE;
        end else if (timer_q == TMAX) begin
          state_d = S_DONE;
          expire  = 1'b1;
        end
      end
      S_DONE:    if (rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Lanes are registered, so they are derived from the state being entered.
  always_comb begin
    opa_d = 4'h0;
    opb_d = 4'h0;
    if (state_d == S_START) begin
      opa_d = 4'hF;
      opb_d = 4'hF;
    end else if (state_d == S_SEND) begin
      opa_d = rs1_q[{idx_d, 2'b00} +: 4];
      opb_d = rs2_q[{idx_d, 2'b00} +: 4];
    end
  end

  always_ff @(posedge UserCLK) begin
    if (reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      count_q     <= '0;
      timer_q     <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      opa_o       <= 4'h0;
      opb_o       <= 4'h0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_status  <= 4'h0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      opa_o     <= opa_d;
      opb_o     <= opb_d;
      rsp_valid <= (state_d == S_DONE);
      busy      <= (state_d != S_IDLE);
      if (accept) begin
        rs1_q       <= cmd_rs1;
        rs2_q       <= cmd_rs2;
        count_q     <= '0;
        timer_q     <= '0;
        rsp_data    <= '0;
        rsp_status  <= 4'h0;
        rsp_err     <= 1'b0;
        rsp_timeout <= 1'b0;
      end else begin
        if (capture) begin
          rsp_data <= rsp_data | (DATA_WIDTH'(res0_i) << {count_q, 2'b00});
          count_q  <= count_nx;
          rsp_err  <= rsp_err | res1_i[1];
          if (full_now) rsp_status <= res2_i;
        end
        if (state_q == S_COLLECT) timer_q <= timer_q + 1'b1;
        if (expire) rsp_timeout <= 1'b1;
      end
    end
  end

endmodule
